beat_timer: RTL



---
 rtl/beat_timer_if.sv | 25 ++
 rtl/beat_timer.sv | 99 +++++++++
 2 files changed

// File: rtl/beat_timer_if.sv
// Note-timing handshake between sequencer (master) and beat timer (slave).
// Sequencer drives start/beat/speed/pause/stop; the timer returns busy/done/err/remaining.
interface beat_timer_if #(
  parameter int CNT_W = 28
);
  logic             start;
  logic [3:0]       beat;
  logic [1:0]       speed;
  logic             pause;
  logic             stop;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] remaining;

  modport master (
    output start, beat, speed, pause, stop,
    input  busy, done, err, remaining
  );

  modport slave (
    input  start, beat, speed, pause, stop,
    output busy, done, err, remaining
  );
endinterface

// File: rtl/beat_timer.sv
// Beat-code to cycle-count note timer: busy from the cycle after start for N unpaused cycles.
// done/err are registered one-cycle pulses; stop or a new start abandons the note without done.
module beat_timer #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned WHOLE_MS    = 1600,
  parameter int          CNT_W       = 28
) (
  input  logic     clk,
  input  logic     rst_n,
  beat_timer_if.slave tmr
);

  localparam longint unsigned WHOLE = 64'(CLK_FREQ_HZ) / 64'd1000 * 64'(WHOLE_MS);
  localparam logic [CNT_W-1:0] WHOLE_C = CNT_W'(WHOLE);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // A dotted whole note is the longest duration the counter ever has to hold.
  if ((WHOLE + WHOLE / 64'd2) >= (64'd1 << CNT_W)) begin : g_width_chk
    $error("beat_timer: CNT_W too narrow for 1.5 x whole-note cycles");
  end

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] base, dur, n_load;

  always_comb begin
    base   = WHOLE_C >> tmr.beat[2:0];
    dur    = tmr.beat[3] ? (base + (base >> 1)) : base;
    n_load = dur >> tmr.speed;
    if (n_load == '0) n_load = ONE;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (tmr.stop) begin
      state_d = S_IDLE;
      rem_d   = '0;
    end else if (tmr.start) begin
      if (tmr.beat[2:0] == 3'd7) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
        rem_d   = '0;
      end else begin
        rem_d   = n_load;
        state_d = tmr.pause ? S_PAUSED : S_RUN;
      end
    end else begin
      case (state_q)
        // Leaving PAUSED counts immediately, so only pause-high cycles stretch the note.
        S_RUN, S_PAUSED: begin
          if (tmr.pause) begin
            state_d = S_PAUSED;
          end else if (rem_q == ONE) begin
            state_d = S_IDLE;
            rem_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            rem_d   = rem_q - ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign tmr.busy      = (state_q != S_IDLE);
  assign tmr.done      = done_q;
  assign tmr.err       = err_q;
  assign tmr.remaining = rem_q;

endmodule
